// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_pkg
// Brief  : Shared FSM states, parity encodings and divisor helper for the UART.
// Rev    : 1.0  initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } tx_state_t;

  localparam logic [1:0] PAR_NONE  = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_EVEN  = 2'b10;
  localparam logic [1:0] PAR_NONE2 = 2'b11;

  // Zero selects the build-time default; one would leave no room for a
  // counter boundary, so it is stretched to two.
  function automatic logic [31:0] eff_div(input logic [31:0] raw, input logic [31:0] def_div);
    if (raw == 32'd0)
      return def_div;
    else if (raw == 32'd1)
      return 32'd2;
    else
      return raw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module : uart_sync_fifo
// Brief  : Single-clock FIFO with registered read data and occupancy count.
// Rev    : 1.0  initial release
// ============================================================================
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      rdata  <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
        rdata  <= mem[rd_ptr];
      end
      if (push_ok && !pop_ok)
        level <= level + LW'(1);
      else if (pop_ok && !push_ok)
        level <= level - LW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_buffered
// Brief  : FIFO-buffered UART transmitter with per-frame divisor/parity/stop.
// Rev    : 1.0  initial release
// ============================================================================
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_FRE    = 100,
  parameter int DEF_BAUD   = 9600,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          i_clk_sys,
  input  logic                          i_rst,
  input  logic [DATA_WIDTH-1:0]         i_data_tx,
  input  logic                          i_data_valid,
  output logic                          o_data_ready,
  input  logic [DIV_WIDTH-1:0]          i_baud_div,
  input  logic [1:0]                    i_parity_mode,
  input  logic                          i_stop2,
  output logic                          o_uart_tx,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic                          o_done
);

  localparam logic [31:0] DEF_DIV = 32'((CLK_FRE * 1_000_000 + DEF_BAUD / 2) / DEF_BAUD);
  localparam int          BW      = $clog2(DATA_WIDTH);

  tx_state_t             state;
  logic                  pending;
  logic                  tx_line;
  logic                  done_pulse;
  logic [31:0]           baud_cnt;
  logic [31:0]           div_q;
  logic [1:0]            mode_q;
  logic                  stop2_q;
  logic                  stop_idx;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift;
  logic                  par_bit;

  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic                  baud_last;
  logic                  stop_end;
  logic                  par_en;

  assign o_data_ready = !fifo_full;
  assign push         = i_data_valid && !fifo_full;
  assign baud_last    = (baud_cnt == div_q - 32'd1);
  assign stop_end     = (state == S_STOP) && baud_last && !(stop2_q && !stop_idx);
  assign par_en       = (mode_q == PAR_ODD) || (mode_q == PAR_EVEN);
  // A finishing frame pops its successor on its final edge so the next start
  // bit follows after a single idle cycle.
  assign pop          = !fifo_empty && (((state == S_IDLE) && !pending) || stop_end);

  assign o_uart_tx    = tx_line;
  assign o_busy       = (state != S_IDLE);
  assign o_done       = done_pulse;

  uart_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk_sys),
    .rst   (i_rst),
    .push  (push),
    .wdata (i_data_tx),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (o_fifo_level)
  );

  always_ff @(posedge i_clk_sys) begin
    if (i_rst) begin
      state      <= S_IDLE;
      pending    <= 1'b0;
      tx_line    <= 1'b1;
      done_pulse <= 1'b0;
      baud_cnt   <= '0;
      div_q      <= 32'd2;
      mode_q     <= PAR_NONE;
      stop2_q    <= 1'b0;
      stop_idx   <= 1'b0;
      bit_cnt    <= '0;
      shift      <= '0;
      par_bit    <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      if (pop) begin
        div_q   <= eff_div(32'(i_baud_div), DEF_DIV);
        mode_q  <= i_parity_mode;
        stop2_q <= i_stop2;
        pending <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          baud_cnt <= '0;
          if (pending) begin
            pending  <= 1'b0;
            state    <= S_START;
            tx_line  <= 1'b0;
            shift    <= fifo_rdata;
            par_bit  <= (^fifo_rdata) ^ (mode_q == PAR_ODD);
          end
        end
        S_START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= S_DATA;
            tx_line  <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + 32'd1;
          end
        end
        S_DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
              if (par_en) begin
                state   <= S_PARITY;
                tx_line <= par_bit;
              end else begin
                state    <= S_STOP;
                tx_line  <= 1'b1;
                stop_idx <= 1'b0;
              end
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              shift   <= shift >> 1;
              tx_line <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 32'd1;
          end
        end
        S_PARITY: begin
          if (baud_last) begin
            baud_cnt <= '0;
            state    <= S_STOP;
            tx_line  <= 1'b1;
            stop_idx <= 1'b0;
          end else begin
            baud_cnt <= baud_cnt + 32'd1;
          end
        end
        S_STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (stop2_q && !stop_idx) begin
              stop_idx <= 1'b1;
            end else begin
              state      <= S_IDLE;
              done_pulse <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 32'd1;
          end
        end
        default: begin
          state   <= S_IDLE;
          tx_line <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
